decode_queue: RTL

Registered decode buffer between fetch and issue in the MIPS core. Accepts up to FETCH_WIDTH fetched instructions per cycle, decodes each into register-file fields on enqueue, stores them in a circular queue of DEPTH entries, and presents up to ISSUE_WIDTH in-order decoded entries per cycle to issue. It supports flush on branch/exception redirect and defers movn/movz write-enable resolution to execute.

---
 rtl/decode_queue_pkg.sv | 21 ++
 rtl/decode_queue_if.sv | 22 ++
 rtl/decode_queue_field_decode.sv | 58 +++++
 rtl/decode_queue.sv | 67 ++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: decoded-entry type, MIPS opcode/funct codes and field widths
package decode_queue_pkg;
   localparam int WORD_W = 32;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_RA = 5'd31;
   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_JAL = 6'h03;
   localparam logic [5:0] OP_COP0 = 6'h10, OP_SPECIAL2 = 6'h1c;
   localparam logic [5:0] FN_MOVZ = 6'h0a, FN_MOVN = 6'h0b, FN_ERET = 6'h18;
   localparam logic [REG_W-1:0] CP0_MF = 5'h00, CP0_MT = 5'h04, CP0_CO = 5'h10;
   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [REG_W-1:0]  wreg;
      logic              wen;
      logic              movc;
      logic              ri;
   } dec_entry_t;
endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side enqueue and issue-side dequeue signals of the decode queue
interface decode_queue_if
   import decode_queue_pkg::*;
#(
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2,
   parameter int DEPTH = 8
);
   logic                                flush;
   logic [FETCH_WIDTH-1:0]              in_valid;
   logic [FETCH_WIDTH-1:0][WORD_W-1:0]  in_instr;
   logic [FETCH_WIDTH-1:0][WORD_W-1:0]  in_pc;
   logic                                in_ready;
   logic [ISSUE_WIDTH-1:0]              out_valid;
   dec_entry_t [ISSUE_WIDTH-1:0]        out_entry;
   logic [$clog2(ISSUE_WIDTH+1)-1:0]    out_take;
   logic [$clog2(DEPTH+1)-1:0]          count;
   modport master (output flush, in_valid, in_instr, in_pc, out_take,
                   input in_ready, out_valid, out_entry, count);
   modport slave (input flush, in_valid, in_instr, in_pc, out_take,
                  output in_ready, out_valid, out_entry, count);
endinterface

// File: rtl/decode_queue_field_decode.sv
// decode_queue_field_decode: combinational MIPS word -> register-file fields (pc left zero)
module decode_queue_field_decode
   import decode_queue_pkg::*;
(
   input  logic [WORD_W-1:0] instr_i,
   output dec_entry_t        entry_o
);
   logic [5:0] op, fn;
   logic [REG_W-1:0] rs, rt, rd;
   logic sup, wr, to_rt, to_ra, mov;
   assign {op, rs, rt, rd} = instr_i[31:11];
   assign fn = instr_i[5:0];
   always_comb begin
      sup = 1'b0;
      wr = 1'b0;
      to_rt = 1'b0;
      to_ra = 1'b0;
      mov = 1'b0;
      case (op)
         OP_SPECIAL: begin
            sup = fn inside {6'h00, [6'h02:6'h04], [6'h06:6'h0d], 6'h0f, [6'h10:6'h13], [6'h18:6'h1b],
                             [6'h20:6'h27], 6'h2a, 6'h2b, [6'h30:6'h34], 6'h36};
            wr = fn inside {6'h00, [6'h02:6'h04], 6'h06, 6'h07, 6'h09, 6'h10, 6'h12, [6'h20:6'h27], 6'h2a, 6'h2b};
            mov = fn inside {FN_MOVZ, FN_MOVN};
         end
         OP_REGIMM: begin
            sup = rt inside {[5'h00:5'h03], [5'h10:5'h13]};
            wr = rt inside {[5'h10:5'h13]};
            to_ra = wr;
         end
         OP_JAL: {sup, wr, to_ra} = 3'b111;
         OP_COP0: begin
            sup = rs == CP0_MF || rs == CP0_MT || (rs == CP0_CO && fn == FN_ERET);
            wr = rs == CP0_MF;
            to_rt = wr;
         end
         OP_SPECIAL2: begin
            sup = fn inside {[6'h00:6'h02], 6'h04, 6'h05, 6'h20, 6'h21};
            wr = fn inside {6'h02, 6'h20, 6'h21};
         end
         default: begin
            sup = op inside {6'h02, [6'h04:6'h0f], [6'h14:6'h17], [6'h20:6'h26], [6'h28:6'h2b],
                             6'h2e, 6'h2f, 6'h30, 6'h33, 6'h38};
            wr = op inside {[6'h08:6'h0f], [6'h20:6'h26], 6'h30, 6'h38};
            to_rt = wr;
         end
      endcase
      entry_o.pc = '0;
      entry_o.instr = instr_i;
      entry_o.rs = rs;
      entry_o.rt = rt;
      entry_o.rd = rd;
      entry_o.wreg = to_ra ? REG_RA : to_rt ? rt : rd;
      entry_o.wen = wr && entry_o.wreg != '0 && instr_i != '0;
      entry_o.movc = mov;
      entry_o.ri = ~sup;
   end
endmodule

// File: rtl/decode_queue.sv
// decode_queue: circular buffer of decoded instructions between fetch and issue
// Entries are decoded on enqueue; movn/movz leave write-enable resolution to execute.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2,
   parameter int DEPTH = 8
) (
   input logic           clk,
   input logic           resetn,
   decode_queue_if.slave q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   dec_entry_t [FETCH_WIDTH-1:0] dec;
   dec_entry_t lane_e [FETCH_WIDTH];
   dec_entry_t mem_q [DEPTH];
   logic [PW-1:0] wa [FETCH_WIDTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d, n_in, n_enq;
   logic enq;
   genvar i;
   for (i = 0; i < FETCH_WIDTH; i++) begin : g_dec
      decode_queue_field_decode u_dec (.instr_i(q.in_instr[i]), .entry_o(dec[i]));
   end
   // valid lanes are packed onto consecutive slots starting at the tail
   always_comb begin
      n_in = '0;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         lane_e[k] = dec[k];
         lane_e[k].pc = q.in_pc[k];
         wa[k] = tail_q + n_in[PW-1:0];
         n_in = n_in + CW'(q.in_valid[k]);
      end
      enq = q.in_ready & ~q.flush;
      n_enq = enq ? n_in : '0;
      head_d = q.flush ? '0 : head_q + PW'(q.out_take);
      tail_d = q.flush ? '0 : tail_q + n_enq[PW-1:0];
      count_d = q.flush ? '0 : count_q + n_enq - CW'(q.out_take);
   end
   always_comb begin
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         q.out_valid[k] = count_q > CW'(k);
         q.out_entry[k] = mem_q[head_q + PW'(k)];
      end
   end
   assign q.in_ready = count_q <= CW'(DEPTH - FETCH_WIDTH);
   assign q.count = count_q;
   always_ff @(posedge clk) begin
      for (int k = 0; k < FETCH_WIDTH; k++)
         if (enq && q.in_valid[k]) mem_q[wa[k]] <= lane_e[k];
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
      end
   end
   assert property (@(posedge clk) disable iff (!resetn)
      !q.flush |-> int'(q.out_take) <= ISSUE_WIDTH && CW'(q.out_take) <= count_q);
endmodule
